// File: rtl/instruction_fetch.sv
// Purpose: fetch stage that reads a combinational ROM at the PC and presents instructions to decode. It absorbs NOP (timed delay) and JMP words internally.
// Latency: one cycle from a fetched address to the registered oInstruction; a JMP costs one bubble cycle, and a NOP of count N stalls for N cycles.
// Backpressure: valid/ready on the output. While oValid=1 and iReady=0, fetch holds PC and output. A branch redirect overrides everything.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter logic [3:0]  NOP_OP   = 4'h0,
  parameter logic [3:0]  JMP_OP   = 4'h1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic        oBusy
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DELAY = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [23:0] cnt, cnt_nxt;
  logic [27:0] instr_q, instr_nxt;
  logic        vld_q, vld_nxt;

  // Field decode of the ROM word at the current PC
  logic [3:0]  opcode;
  logic [23:0] nop_cnt;
  logic [7:0]  jmp_tgt;
  logic        slot_free;

  assign opcode    = iInstruction[27:24];
  assign nop_cnt   = iInstruction[23:0];
  assign jmp_tgt   = iInstruction[23:16];
  assign slot_free = !vld_q || iReady;

  assign oAddress     = pc;
  assign oInstruction = instr_q;
  assign oValid       = vld_q;
  assign oBusy        = (state == DELAY);

  // State register: all fetch state, cleared asynchronously by Reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      cnt     <= 24'd0;
      instr_q <= 28'd0;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cnt     <= cnt_nxt;
      instr_q <= instr_nxt;
      vld_q   <= vld_nxt;
    end
  end

  // Next-state logic: redirect first, then RUN fetch/absorb or DELAY countdown
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    instr_nxt = instr_q;
    vld_nxt   = vld_q;

    if (iBranchTaken) begin
      // The word fetched this cycle is dropped along with any pending output
      state_nxt = RUN;
      pc_nxt    = iBranchTarget;
      cnt_nxt   = 24'd0;
      vld_nxt   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (slot_free) begin
            // Slot is empty or being drained; clear unless a real instruction loads
            vld_nxt = 1'b0;
            if (opcode == NOP_OP) begin
              if (nop_cnt == 24'd0) begin
                pc_nxt = pc + 16'd1;
              end else begin
                // PC stays on the NOP; it advances when the countdown expires
                state_nxt = DELAY;
                cnt_nxt   = nop_cnt - 24'd1;
              end
            end else if (opcode == JMP_OP) begin
              pc_nxt = {8'h00, jmp_tgt};
            end else begin
              instr_nxt = iInstruction;
              vld_nxt   = 1'b1;
              pc_nxt    = pc + 16'd1;
            end
          end
        end
        DELAY: begin
          // The output handshake still completes while stalled
          if (vld_q && iReady) begin
            vld_nxt = 1'b0;
          end
          if (cnt == 24'd0) begin
            pc_nxt    = pc + 16'd1;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 24'd1;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: directed, table-driven check of instruction_fetch against a small ROM image.
// Latency: per-cycle vectors compare outputs on the falling edge, before the next rising edge.
// Backpressure: iReady stalls, branch redirects and reset corner cases are driven as hand-written sequences.
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oBusy;

  int checks = 0;
  int errors = 0;

  logic [27:0] rom_mem [0:255];

  instruction_fetch dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .oInstruction  (oInstruction),
    .oValid        (oValid),
    .iReady        (iReady),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oBusy         (oBusy)
  );

  always #5 Clock = ~Clock;

  // ROM: the table covers the low 256 words; everything above reads as an ADD tagged with its address
  always_comb begin
    if (oAddress < 16'd256) iInstruction = rom_mem[oAddress[7:0]];
    else                    iInstruction = {4'h2, 8'h00, oAddress};
  end

  typedef struct {
    logic        rdy;
    logic        bt;
    logic [15:0] btgt;
    logic [15:0] exp_addr;
    logic        exp_vld;
    logic [27:0] exp_instr;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [0:14];

  task automatic check(input string name, input logic [15:0] e_addr, input logic e_vld,
                       input logic [27:0] e_instr, input logic chk_instr, input logic e_busy);
    checks++;
    if (oAddress !== e_addr) begin
      errors++;
      $display("FAIL %s oAddress got %h want %h", name, oAddress, e_addr);
    end
    checks++;
    if (oValid !== e_vld) begin
      errors++;
      $display("FAIL %s oValid got %b want %b", name, oValid, e_vld);
    end
    checks++;
    if (oBusy !== e_busy) begin
      errors++;
      $display("FAIL %s oBusy got %b want %b", name, oBusy, e_busy);
    end
    if (chk_instr) begin
      checks++;
      if (oInstruction !== e_instr) begin
        errors++;
        $display("FAIL %s oInstruction got %h want %h", name, oInstruction, e_instr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = {4'h2, 8'h00, i[15:0]};
    rom_mem[0]    = 28'h2000001;  // ADD
    rom_mem[1]    = 28'h2000002;  // ADD
    rom_mem[2]    = 28'h2000003;  // ADD
    rom_mem[3]    = 28'h10A0000;  // JMP 10
    rom_mem[10]   = 28'h300000A;  // other op
    rom_mem[11]   = 28'h0000005;  // NOP 5
    rom_mem[12]   = 28'h200000C;  // ADD
    rom_mem[13]   = 28'h0000000;  // NOP 0
    rom_mem[14]   = 28'h200000E;  // ADD
    rom_mem[8'h40] = 28'h0000BB9; // NOP 3001 -> counter 3000 on entry
    rom_mem[8'h50] = 28'h0000064; // NOP 100

    //            rdy   bt    btgt   addr    vld   instr         busy
    vecs[0]  = '{1'b1, 1'b0, 16'h0, 16'd0,  1'b0, 28'h0000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0, 16'd1,  1'b1, 28'h2000001, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0, 16'd2,  1'b1, 28'h2000002, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0, 16'd3,  1'b1, 28'h2000003, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0, 16'd10, 1'b0, 28'h0000000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0, 16'd11, 1'b1, 28'h300000A, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0, 16'd11, 1'b0, 28'h0000000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'h0, 16'd11, 1'b0, 28'h0000000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0, 16'd11, 1'b0, 28'h0000000, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0, 16'd11, 1'b0, 28'h0000000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h0, 16'd11, 1'b0, 28'h0000000, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 16'h0, 16'd12, 1'b0, 28'h0000000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'h0, 16'd13, 1'b1, 28'h200000C, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'h0, 16'd14, 1'b0, 28'h0000000, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'h0, 16'd15, 1'b1, 28'h200000E, 1'b0};

    Reset = 1'b0;
    iReady = 1'b1;
    iBranchTaken = 1'b0;
    iBranchTarget = 16'h0;
    repeat (2) @(negedge Clock);
    check("reset", 16'd0, 1'b0, 28'd0, 1'b1, 1'b0);
    Reset = 1'b1;

    // Straight-line fetch, JMP absorption, NOP 5 delay, NOP 0 skip
    for (int i = 0; i < 15; i++) begin
      check($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_vld,
            vecs[i].exp_instr, vecs[i].exp_vld, vecs[i].exp_busy);
      iReady        = vecs[i].rdy;
      iBranchTaken  = vecs[i].bt;
      iBranchTarget = vecs[i].btgt;
      @(negedge Clock);
    end

    // Backpressure: four stalled cycles, then the next word loads on release
    check("bp_pre", 16'd16, 1'b1, 28'h200000F, 1'b1, 1'b0);
    iReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check($sformatf("bp_hold%0d", k), 16'd16, 1'b1, 28'h200000F, 1'b1, 1'b0);
    end
    iReady = 1'b1;
    @(negedge Clock);
    check("bp_release", 16'd17, 1'b1, 28'h2000010, 1'b1, 1'b0);

    // Branch flushes pending output, then a branch during a long DELAY
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0040;
    @(negedge Clock);
    check("br_flush", 16'h0040, 1'b0, 28'd0, 1'b0, 1'b0);
    iBranchTaken = 1'b0;
    @(negedge Clock);
    check("br_in_delay", 16'h0040, 1'b0, 28'd0, 1'b0, 1'b1);
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0020;
    @(negedge Clock);
    check("br_exit_delay", 16'h0020, 1'b0, 28'd0, 1'b0, 1'b0);
    iBranchTaken = 1'b0;

    // Reset asserted mid-DELAY, fetch resumes at RESET_PC, then PC wraps
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0050;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    @(negedge Clock);
    check("rst_pre_delay", 16'h0050, 1'b0, 28'd0, 1'b0, 1'b1);
    #2 Reset = 1'b0;
    #1 check("rst_async", 16'd0, 1'b0, 28'd0, 1'b1, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_resume", 16'd1, 1'b1, 28'h2000001, 1'b1, 1'b0);
    iBranchTaken = 1'b1;
    iBranchTarget = 16'hFFFF;
    @(negedge Clock);
    check("wrap_pre", 16'hFFFF, 1'b0, 28'd0, 1'b0, 1'b0);
    iBranchTaken = 1'b0;
    @(negedge Clock);
    check("wrap", 16'h0000, 1'b1, 28'h200FFFF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0, meaning program counter value after reset.
REQ-002 SHALL have parameter NOP_OP, default 4'h0, meaning opcode field value treated as timed NOP; it is bound to the project opcode definitions at instantiation.
REQ-003 SHALL have parameter JMP_OP, default 4'h1, meaning opcode field value treated as unconditional jump; it is bound to the project opcode definitions at instantiation.
REQ-004 SHALL have port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port oAddress, output, 16 bits, current PC; drives the combinational instruction ROM address.
REQ-007 SHALL have port iInstruction, input, 28 bits, ROM word at oAddress, valid in the same cycle.
REQ-008 SHALL have port oInstruction, output, 28 bits, registered instruction presented to decode.
REQ-009 SHALL have port oValid, output, 1 bit, oInstruction holds an instruction not yet accepted.
REQ-010 SHALL have port iReady, input, 1 bit, decode accepts oInstruction this cycle when oValid=1.
REQ-011 SHALL have port iBranchTaken, input, 1 bit, execute-stage redirect request (single-cycle pulse).
REQ-012 SHALL have port iBranchTarget, input, 16 bits, redirect address, sampled when iBranchTaken=1.
REQ-013 SHALL have port oBusy, output, 1 bit, high while in the DELAY state.

Function
REQ-014 SHALL decode iInstruction as opcode [27:24], NOP count [23:0], and JMP target [23:16] zero-extended to 16 bits.
REQ-015 SHALL implement states RUN and DELAY with a 16-bit PC register and a 24-bit delay counter.
REQ-016 SHALL define slot free as (oValid=0) or (oValid=1 and iReady=1).
REQ-017 SHALL, in RUN with slot free and opcode neither NOP_OP nor JMP_OP, load oInstruction<=iInstruction, set oValid<=1, and set PC<=PC+1; fetch-to-output latency is one cycle.
REQ-018 SHALL, in RUN with slot free and opcode NOP_OP with count 0, set PC<=PC+1 and emit nothing.
REQ-019 SHALL, in RUN with slot free and opcode NOP_OP with count N>0, enter DELAY with counter<=N-1; PC is unchanged.
REQ-020 SHALL, in DELAY, decrement the counter each cycle; the cycle the counter equals 0 it sets PC<=PC+1 and returns to RUN, giving exactly N cycles in DELAY.
REQ-021 SHALL, in RUN with slot free and opcode JMP_OP, set PC<=target and emit nothing; the jump costs one cycle.
REQ-022 SHALL never emit NOP or JMP words on oInstruction.
REQ-023 SHALL, with oValid=1 and iReady=0 in RUN, hold oInstruction, oValid and PC unchanged (no fetch advance).
REQ-024 SHALL, when oValid=1 and iReady=1 and no new instruction is loaded that cycle, clear oValid<=0.
REQ-025 SHALL let DELAY not block the handshake: a pending oValid is still cleared on iReady during DELAY.
REQ-026 SHALL give iBranchTaken=1 highest priority in any state: PC<=iBranchTarget, oValid<=0 (flush), state<=RUN, counter<=0; the fetched word that cycle is discarded.
REQ-027 SHALL wrap PC from 16'hFFFF to 16'h0000 on increment.
REQ-028 SHALL drive oAddress=PC and oBusy=(state==DELAY) combinationally from registers.
REQ-029 SHALL keep oInstruction stable whenever oValid=1 and iReady=0.

Reset
REQ-030 SHALL, on Reset=0 (asynchronous, any cycle including mid-DELAY), force PC=RESET_PC, state=RUN, counter=0, oValid=0, and oInstruction=28'd0; hence oAddress=RESET_PC and oBusy=0.
REQ-031 SHALL resume fetching from RESET_PC on the first rising edge after Reset deasserts.

Verification
REQ-032 SHALL be verified by this scenario: ROM 0:ADD,1:ADD,2:ADD with iReady=1 -> oValid high from cycle 1, oInstruction sequence ROM[0..2], oAddress 0,1,2,3.
REQ-033 SHALL be verified by this scenario: ROM 0:NOP count 5, 1:ADD -> oBusy high exactly 5 cycles, PC holds 0, then ADD appears on oInstruction; no NOP is emitted.
REQ-034 SHALL be verified by this scenario: ROM 3:JMP target 8'd10 -> oAddress goes 3 to 10 next cycle; no output for the JMP; ROM[10] is emitted next.
REQ-035 SHALL be verified by this scenario: iReady=0 for 4 cycles with oValid=1 -> oInstruction and oAddress frozen; on iReady=1, the next word loads the same cycle.
REQ-036 SHALL be verified by this scenario: iBranchTaken=1 with target 16'h0020 during DELAY with counter 3000 -> next cycle oBusy=0, oValid=0, oAddress=16'h0020.
REQ-037 SHALL be verified by this scenario: Reset asserted mid-DELAY, then PC=16'hFFFF on ADD -> all outputs at reset values immediately; after release, increment wraps oAddress to 16'h0000.
